// File: rtl/div_seq.sv
// Iterative 32-bit radix-2 restoring divider for the EXE stage.
// Works on operand magnitudes, then applies the quotient/remainder sign correction.

module div_seq (
   input  logic        clk,
   input  logic        resetn,
   input  logic        div_en,
   input  logic        div_sign,
   input  logic [31:0] div_src1,
   input  logic [31:0] div_src2,
   input  logic        div_ack,
   input  logic        div_flush,
   output logic        div_complete,
   output logic        div_busy,
   output logic [31:0] div_quotient,
   output logic [31:0] div_remainder
);

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dsr_q, dsr_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic        zero_div_q, zero_div_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rmd_q, rmd_d;

   logic [31:0] src1_abs;
   logic [31:0] src2_abs;
   logic [32:0] rem_shift;
   logic        sub_ok;
   logic [31:0] rem_sub;
   logic [31:0] rem_step;
   logic [31:0] quo_raw;

   always_comb begin
      src1_abs = (div_sign && div_src1[31]) ? (32'd0 - div_src1) : div_src1;
      src2_abs = (div_sign && div_src2[31]) ? (32'd0 - div_src2) : div_src2;
   end

   // One restoring step; the 33-bit shifted remainder keeps the compare exact.
   always_comb begin
      rem_shift = {rem_q, dvd_q[31]};
      sub_ok    = (rem_shift >= {1'b0, dsr_q});
      rem_sub   = rem_shift[31:0] - dsr_q;
      rem_step  = sub_ok ? rem_sub : rem_shift[31:0];
      quo_raw   = {dvd_q[30:0], sub_ok};
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dvd_d      = dvd_q;
      rem_d      = rem_q;
      dsr_d      = dsr_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      zero_div_d = zero_div_q;
      quo_d      = quo_q;
      rmd_d      = rmd_q;

      unique case (state_q)
         StIdle: begin
            if (div_en && !div_flush) begin
               dvd_d      = src1_abs;
               dsr_d      = src2_abs;
               rem_d      = 32'd0;
               q_neg_d    = div_sign && (div_src1[31] ^ div_src2[31]);
               r_neg_d    = div_sign && div_src1[31];
               zero_div_d = (div_src2 == 32'd0);
               cnt_d      = 6'd0;
               state_d    = StCalc;
            end
         end
         StCalc: begin
            dvd_d = quo_raw;
            rem_d = rem_step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = StDone;
               // With a zero divisor every step subtracts 0, so rem_step is the latched dividend.
               if (zero_div_q) begin
                  quo_d = 32'hFFFF_FFFF;
                  rmd_d = rem_step;
               end else begin
                  quo_d = q_neg_q ? (32'd0 - quo_raw) : quo_raw;
                  rmd_d = r_neg_q ? (32'd0 - rem_step) : rem_step;
               end
            end
         end
         StDone: begin
            if (div_ack) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (div_flush) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         cnt_q      <= 6'd0;
         dvd_q      <= 32'd0;
         rem_q      <= 32'd0;
         dsr_q      <= 32'd0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         zero_div_q <= 1'b0;
         quo_q      <= 32'd0;
         rmd_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dvd_q      <= dvd_d;
         rem_q      <= rem_d;
         dsr_q      <= dsr_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
         zero_div_q <= zero_div_d;
         quo_q      <= quo_d;
         rmd_q      <= rmd_d;
      end
   end

   always_comb begin
      div_complete  = (state_q == StDone);
      div_busy      = (state_q == StCalc);
      div_quotient  = quo_q;
      div_remainder = rmd_q;
   end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, hand-written corner sequences,
// and randomized divides checked against an arithmetic reference model.

module tb_div_seq;

   logic        clk;
   logic        resetn;
   logic        div_en;
   logic        div_sign;
   logic [31:0] div_src1;
   logic [31:0] div_src2;
   logic        div_ack;
   logic        div_flush;
   logic        div_complete;
   logic        div_busy;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;

   int n_total = 0;
   int n_pass  = 0;

   div_seq dut (
      .clk          (clk),
      .resetn       (resetn),
      .div_en       (div_en),
      .div_sign     (div_sign),
      .div_src1     (div_src1),
      .div_src2     (div_src2),
      .div_ack      (div_ack),
      .div_flush    (div_flush),
      .div_complete (div_complete),
      .div_busy     (div_busy),
      .div_quotient (div_quotient),
      .div_remainder(div_remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer division, truncating toward zero.
   function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = (s && a[31]) ? (32'd0 - a) : a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      while (!div_complete && lat < 100) begin
         step();
         lat++;
      end
   endtask

   // Full divide with ack raised as soon as complete is seen.
   task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
      div_sign = s;
      div_src1 = a;
      div_src2 = b;
      div_en   = 1'b1;
      step();
      chk("busy_after_start", 32'(div_busy), 32'd1);
      wait_done(lat);
      q = div_quotient;
      r = div_remainder;
      div_ack = 1'b1;
      step();
      div_ack = 1'b0;
      div_en  = 1'b0;
      chk("complete_after_ack", 32'(div_complete), 32'd0);
      chk("busy_after_ack", 32'(div_busy), 32'd0);
   endtask

   initial begin
      logic [31:0] q, r, eq, er, q0, r0;
      int          lat;
      logic        s;
      logic [31:0] a, b;

      tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
      tbl[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
      tbl[3] = '{1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234};
      tbl[4] = '{1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15};
      tbl[5] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2};
      tbl[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};

      resetn    = 1'b0;
      div_en    = 1'b0;
      div_sign  = 1'b0;
      div_src1  = 32'd0;
      div_src2  = 32'd0;
      div_ack   = 1'b0;
      div_flush = 1'b0;
      #12;
      chk("reset_complete", 32'(div_complete), 32'd0);
      chk("reset_busy", 32'(div_busy), 32'd0);
      chk("reset_quotient", div_quotient, 32'd0);
      chk("reset_remainder", div_remainder, 32'd0);
      #10 resetn = 1'b1;

      for (int i = 0; i < 7; i++) begin
         do_div(tbl[i].s, tbl[i].a, tbl[i].b, q, r, lat);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd32);
         chk($sformatf("tbl%0d_quotient", i), q, tbl[i].q);
         chk($sformatf("tbl%0d_remainder", i), r, tbl[i].r);
      end

      // Flush mid-CALC with div_en held; the restart picks up 9 / 3.
      div_sign = 1'b0;
      div_src1 = 32'd20;
      div_src2 = 32'd3;
      div_en   = 1'b1;
      step();
      repeat (10) step();
      div_flush = 1'b1;
      div_src1  = 32'd9;
      div_src2  = 32'd3;
      step();
      div_flush = 1'b0;
      chk("flush_busy", 32'(div_busy), 32'd0);
      chk("flush_complete", 32'(div_complete), 32'd0);
      step();
      chk("flush_restart_busy", 32'(div_busy), 32'd1);
      wait_done(lat);
      chk("flush_restart_latency", 32'(lat), 32'd32);
      chk("flush_restart_quotient", div_quotient, 32'd3);
      chk("flush_restart_remainder", div_remainder, 32'd0);
      div_ack = 1'b1;
      step();
      div_ack = 1'b0;
      div_en  = 1'b0;

      // Flush together with div_en in IDLE must not start.
      div_en    = 1'b1;
      div_flush = 1'b1;
      step();
      chk("flush_idle_busy", 32'(div_busy), 32'd0);
      div_en    = 1'b0;
      div_flush = 1'b0;

      // Ack withheld 5 cycles while the operand inputs wander.
      div_sign = 1'b1;
      div_src1 = 32'hFFFF_8000;
      div_src2 = 32'd123;
      model(1'b1, 32'hFFFF_8000, 32'd123, q0, r0);
      div_en = 1'b1;
      step();
      wait_done(lat);
      chk("hold_latency", 32'(lat), 32'd32);
      for (int k = 0; k < 5; k++) begin
         div_src1 = $urandom;
         div_src2 = $urandom;
         div_sign = 1'($urandom);
         step();
         chk($sformatf("hold%0d_complete", k), 32'(div_complete), 32'd1);
         chk($sformatf("hold%0d_quotient", k), div_quotient, q0);
         chk($sformatf("hold%0d_remainder", k), div_remainder, r0);
      end
      div_ack = 1'b1;
      step();
      div_ack = 1'b0;
      div_en  = 1'b0;
      chk("hold_ack_complete", 32'(div_complete), 32'd0);

      // Back-to-back with div_en held; latency counted from the edge the first result appeared.
      div_sign = 1'b0;
      div_src1 = 32'd50;
      div_src2 = 32'd5;
      div_en   = 1'b1;
      step();
      wait_done(lat);
      chk("b2b_first_latency", 32'(lat), 32'd32);
      chk("b2b_first_quotient", div_quotient, 32'd10);
      chk("b2b_first_remainder", div_remainder, 32'd0);
      div_ack  = 1'b1;
      div_src1 = 32'hFFFF_FFFF;
      div_src2 = 32'd16;
      step();
      div_ack = 1'b0;
      chk("b2b_ack_complete", 32'(div_complete), 32'd0);
      wait_done(lat);
      chk("b2b_second_latency", 32'(lat + 1), 32'd34);
      chk("b2b_second_quotient", div_quotient, 32'h0FFF_FFFF);
      chk("b2b_second_remainder", div_remainder, 32'd15);
      div_ack = 1'b1;
      step();
      div_ack = 1'b0;
      div_en  = 1'b0;

      // Asynchronous reset mid-CALC.
      div_sign = 1'b0;
      div_src1 = 32'd1000;
      div_src2 = 32'd7;
      div_en   = 1'b1;
      step();
      repeat (15) step();
      #3 resetn = 1'b0;
      #1;
      chk("areset_complete", 32'(div_complete), 32'd0);
      chk("areset_busy", 32'(div_busy), 32'd0);
      chk("areset_quotient", div_quotient, 32'd0);
      chk("areset_remainder", div_remainder, 32'd0);
      div_en = 1'b0;
      #2 resetn = 1'b1;
      do_div(1'b0, 32'd1000, 32'd7, q, r, lat);
      chk("areset_next_latency", 32'(lat), 32'd32);
      chk("areset_next_quotient", q, 32'd142);
      chk("areset_next_remainder", r, 32'd6);

      // Randomized divides against the reference model.
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = $urandom;
         b = $urandom;
         if (i % 4 == 1) b = b >> $urandom_range(31, 8);
         if (i % 5 == 2) a = a >> $urandom_range(31, 4);
         if (b == 32'd0) b = 32'd1;
         model(s, a, b, eq, er);
         do_div(s, a, b, q, r, lat);
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd32);
         chk($sformatf("rnd%0d_quotient s=%0b a=%h b=%h", i, s, a, b), q, eq);
         chk($sformatf("rnd%0d_remainder s=%0b a=%h b=%h", i, s, a, b), r, er);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
